// File: rtl/idct_pkg.sv
// Shared widths, rounding constant and sample types for the 4x4 inverse transform.
package idct_pkg;

  localparam int DW    = 25;
  localparam int IW    = 28;
  localparam int SHIFT = 6;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [IW-1:0] inter_t;

  localparam inter_t RND = inter_t'(1 << (SHIFT - 1));

endpackage

// File: rtl/idct4_1d.sv
// Combinational H.264-style 4-point inverse kernel; optionally rounds and
// shifts the result down for the final column pass.
module idct4_1d
  import idct_pkg::*;
#(
  parameter int OW    = IW,
  parameter bit ROUND = 1'b0
) (
  input  logic [IW-1:0] x0,
  input  logic [IW-1:0] x1,
  input  logic [IW-1:0] x2,
  input  logic [IW-1:0] x3,
  output logic [OW-1:0] y0,
  output logic [OW-1:0] y1,
  output logic [OW-1:0] y2,
  output logic [OW-1:0] y3
);

  inter_t e0, e1, e2, e3;
  inter_t s0, s1, s2, s3;

  always_comb begin
    e0 = inter_t'(x0) + inter_t'(x2);
    e1 = inter_t'(x0) - inter_t'(x2);
    e2 = (inter_t'(x1) >>> 1) - inter_t'(x3);
    e3 = inter_t'(x1) + (inter_t'(x3) >>> 1);
    s0 = e0 + e3;
    s1 = e1 + e2;
    s2 = e1 - e2;
    s3 = e0 - e3;
  end

  // The rounded form floors toward minus infinity after adding half an LSB.
  generate
    if (ROUND) begin : g_rnd
      assign y0 = OW'((s0 + RND) >>> SHIFT);
      assign y1 = OW'((s1 + RND) >>> SHIFT);
      assign y2 = OW'((s2 + RND) >>> SHIFT);
      assign y3 = OW'((s3 + RND) >>> SHIFT);
    end else begin : g_raw
      assign y0 = OW'(s0);
      assign y1 = OW'(s1);
      assign y2 = OW'(s2);
      assign y3 = OW'(s3);
    end
  endgenerate

endmodule

// File: rtl/idct_whole.sv
// Streaming 4x4 inverse transform: row pass into a ping-pong buffer, then a
// rounded column pass that emits one reconstructed column per clock.
module idct_whole
  import idct_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] d_in_1_ori,
  input  logic [DW-1:0] d_in_2_ori,
  input  logic [DW-1:0] d_in_3_ori,
  input  logic [DW-1:0] d_in_4_ori,
  output logic [DW-1:0] d_out_5_fin,
  output logic [DW-1:0] d_out_6_fin,
  output logic [DW-1:0] d_out_7_fin,
  output logic [DW-1:0] d_out_8_fin
);

  logic [IW-1:0] rx [4];
  logic [IW-1:0] ry [4];
  logic [IW-1:0] cx [4];
  logic [DW-1:0] cy [4];

  logic [1:0]    cnt;
  logic          wsel;
  logic [IW-1:0] mem [2][4][4];

  assign rx[0] = {{(IW-DW){d_in_1_ori[DW-1]}}, d_in_1_ori};
  assign rx[1] = {{(IW-DW){d_in_2_ori[DW-1]}}, d_in_2_ori};
  assign rx[2] = {{(IW-DW){d_in_3_ori[DW-1]}}, d_in_3_ori};
  assign rx[3] = {{(IW-DW){d_in_4_ori[DW-1]}}, d_in_4_ori};

  idct4_1d #(.OW(IW), .ROUND(1'b0)) u_row (
    .x0(rx[0]), .x1(rx[1]), .x2(rx[2]), .x3(rx[3]),
    .y0(ry[0]), .y1(ry[1]), .y2(ry[2]), .y3(ry[3])
  );

  // One counter serves both passes: row r of the write bank and column r of
  // the read bank are handled on the same edge.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_col
      assign cx[i] = mem[~wsel][i][cnt];
    end
  endgenerate

  idct4_1d #(.OW(DW), .ROUND(1'b1)) u_col (
    .x0(cx[0]), .x1(cx[1]), .x2(cx[2]), .x3(cx[3]),
    .y0(cy[0]), .y1(cy[1]), .y2(cy[2]), .y3(cy[3])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      wsel        <= 1'b0;
      d_out_5_fin <= '0;
      d_out_6_fin <= '0;
      d_out_7_fin <= '0;
      d_out_8_fin <= '0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            mem[b][i][j] <= '0;
    end else begin
      for (int j = 0; j < 4; j++)
        mem[wsel][cnt][j] <= ry[j];
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3)
        wsel <= ~wsel;
      d_out_5_fin <= cy[0];
      d_out_6_fin <= cy[1];
      d_out_7_fin <= cy[2];
      d_out_8_fin <= cy[3];
    end
  end

endmodule

// File: tb/tb_idct_whole.sv
// Directed, table-driven bench for the streaming 4x4 inverse transform.
module tb_idct_whole;
  import idct_pkg::*;

  logic          clk;
  logic          reset;
  logic [DW-1:0] d_in_1_ori, d_in_2_ori, d_in_3_ori, d_in_4_ori;
  logic [DW-1:0] d_out_5_fin, d_out_6_fin, d_out_7_fin, d_out_8_fin;

  int checks = 0;
  int errors = 0;

  idct_whole dut (
    .clk(clk), .reset(reset),
    .d_in_1_ori(d_in_1_ori), .d_in_2_ori(d_in_2_ori),
    .d_in_3_ori(d_in_3_ori), .d_in_4_ori(d_in_4_ori),
    .d_out_5_fin(d_out_5_fin), .d_out_6_fin(d_out_6_fin),
    .d_out_7_fin(d_out_7_fin), .d_out_8_fin(d_out_8_fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // coef index is row*4+col; expd index is col*4+row of the residual block.
  typedef struct packed {
    logic [15:0][31:0] coef;
    logic [15:0][31:0] expd;
  } vec_t;

  localparam int NV = 6;
  vec_t tab [NV];

  function automatic vec_t mk_row0(input int a, input int b, input int c, input int d,
                                   input int o0, input int o1, input int o2, input int o3);
    vec_t v;
    int o [4];
    v = '0;
    v.coef[0] = a; v.coef[1] = b; v.coef[2] = c; v.coef[3] = d;
    o[0] = o0; o[1] = o1; o[2] = o2; o[3] = o3;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        v.expd[j*4+k] = o[j];
    return v;
  endfunction

  function automatic void kern(input longint a, input longint b, input longint c, input longint d,
                               output longint y0, output longint y1, output longint y2, output longint y3);
    longint e0, e1, e2, e3;
    e0 = a + c;
    e1 = a - c;
    e2 = (b >>> 1) - d;
    e3 = b + (d >>> 1);
    y0 = e0 + e3; y1 = e1 + e2; y2 = e1 - e2; y3 = e0 - e3;
  endfunction

  // Full-range reference: a set mask bit selects -(2^22), a clear bit 2^22-1.
  function automatic vec_t mk_model(input logic [15:0] mask);
    vec_t   v;
    longint m [4][4];
    longint t0, t1, t2, t3;
    v = '0;
    for (int k = 0; k < 16; k++)
      v.coef[k] = mask[k] ? -4194304 : 4194303;
    for (int i = 0; i < 4; i++) begin
      kern(longint'($signed(v.coef[i*4+0])), longint'($signed(v.coef[i*4+1])),
           longint'($signed(v.coef[i*4+2])), longint'($signed(v.coef[i*4+3])), t0, t1, t2, t3);
      m[i][0] = t0; m[i][1] = t1; m[i][2] = t2; m[i][3] = t3;
    end
    for (int j = 0; j < 4; j++) begin
      kern(m[0][j], m[1][j], m[2][j], m[3][j], t0, t1, t2, t3);
      v.expd[j*4+0] = 32'((t0 + 32) >>> 6);
      v.expd[j*4+1] = 32'((t1 + 32) >>> 6);
      v.expd[j*4+2] = 32'((t2 + 32) >>> 6);
      v.expd[j*4+3] = 32'((t3 + 32) >>> 6);
    end
    return v;
  endfunction

  task automatic check_one(input string nm, input logic [DW-1:0] act, input int expv);
    int a;
    a = int'($signed(act));
    checks++;
    if (a != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, a, expv);
    end
  endtask

  task automatic check_output(input string tag, input int e0, input int e1, input int e2, input int e3);
    check_one({tag, " row0"}, d_out_5_fin, e0);
    check_one({tag, " row1"}, d_out_6_fin, e1);
    check_one({tag, " row2"}, d_out_7_fin, e2);
    check_one({tag, " row3"}, d_out_8_fin, e3);
  endtask

  task automatic apply_row(input vec_t v, input int r);
    d_in_1_ori = v.coef[r*4+0][DW-1:0];
    d_in_2_ori = v.coef[r*4+1][DW-1:0];
    d_in_3_ori = v.coef[r*4+2][DW-1:0];
    d_in_4_ori = v.coef[r*4+3][DW-1:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    d_in_1_ori = '0; d_in_2_ori = '0; d_in_3_ori = '0; d_in_4_ori = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Feeds n table blocks back to back then one zero block; expects zeros on
  // the first four edges (fresh banks) and each block's columns one block later.
  task automatic run_stream(input int first, input int n);
    vec_t v;
    vec_t zv;
    zv = '0;
    for (int t = 0; t < 4*(n+1); t++) begin
      int b, r;
      b = t / 4;
      r = t % 4;
      apply_row((b < n) ? tab[first+b] : zv, r);
      @(posedge clk);
      @(negedge clk);
      if (b == 0) begin
        check_output($sformatf("blk%0d fill c%0d", first, r), 0, 0, 0, 0);
      end else begin
        v = tab[first+b-1];
        check_output($sformatf("blk%0d c%0d", first+b-1, r),
                     int'($signed(v.expd[r*4+0])), int'($signed(v.expd[r*4+1])),
                     int'($signed(v.expd[r*4+2])), int'($signed(v.expd[r*4+3])));
      end
    end
  endtask

  initial begin
    vec_t zv;
    zv = '0;
    tab[0] = mk_row0(1440, -720, 0, 0, 11, 17, 28, 34);
    tab[1] = mk_row0(-720, 1440, -720, -720, -6, 23, -22, -39);
    tab[2] = mk_row0(64, 0, 0, 0, 1, 1, 1, 1);
    tab[3] = mk_model(16'h0000);
    tab[4] = mk_model(16'hFFFF);
    tab[5] = mk_model(16'h5A3C);

    reset = 1'b1;
    d_in_1_ori = '0; d_in_2_ori = '0; d_in_3_ori = '0; d_in_4_ori = '0;
    #3 reset = 1'b0;
    #1 check_output("reset state", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int t = 0; t < 8; t++) begin
      apply_row(zv, t % 4);
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("idle c%0d", t % 4), 0, 0, 0, 0);
    end

    $display("[TB] streaming A, B, DC and full-range blocks");
    do_reset();
    run_stream(0, NV);

    // Block A completes, then a DC block is abandoned after row 2 by reset.
    $display("[TB] mid-block reset");
    do_reset();
    for (int t = 0; t < 7; t++) begin
      apply_row((t < 4) ? tab[0] : tab[2], t % 4);
      @(posedge clk);
      @(negedge clk);
      if (t >= 4)
        check_output($sformatf("pre-rst A c%0d", t - 4),
                     int'($signed(tab[0].expd[(t-4)*4])), int'($signed(tab[0].expd[(t-4)*4])),
                     int'($signed(tab[0].expd[(t-4)*4])), int'($signed(tab[0].expd[(t-4)*4])));
    end
    reset = 1'b0;
    #1 check_output("async reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    run_stream(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
